seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed driver for the calculator's four-digit common-anode seven-segment display. It consumes the four per-digit codes (disp0..disp3) produced by the calculator's display-selection logic and scans them onto shared segment lines. Inputs are snapshotted once per frame so a display never mixes old and new digit codes. Each digit slot begins with a programmable anti-ghosting blank interval.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- OFF_CODE, 5'b10000: digit code that blanks a digit.
- One clock; reset is asynchronous and active-low.
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- disp0  input  8  digit code for the rightmost digit (an[0]).
- disp1  input  8  digit code for an[1].
- disp2  input  8  digit code for an[2].
- disp3  input  8  digit code for the leftmost digit (an[3]).
- an  output  4  anode enables, active-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; always 1 (off).
- frame_tick  output  1  one-cycle pulse, high for the cycle after each input snapshot.

## Operation
- Digit code: only bits [4:0] are used; bits [7:5] are ignored.
  - Bit 4 = 1 (any value ≥ 16, including OFF_CODE): the digit is blank, seg = 7'b1111111.
  - Otherwise bits [3:0] select a hex glyph (seg values below are {g..a}):
    - 0..3: 1000000, 1111001, 0100100, 0110000
    - 4..7: 0011001, 0010010, 0000010, 1111000
    - 8..B: 0000000, 0010000, 0001000, 0000011
    - C..F: 1000110, 0100001, 0000110, 0001110
- Slot counter cnt runs 0..REFRESH_DIV-1 and wraps to 0.
  - At the wrap, digit index idx (2-bit) increments modulo 4.
- Shadow registers sh0..sh3:
  - Loaded from disp0..disp3 in the cycle where cnt = REFRESH_DIV-1 and idx = 3, i.e. at the frame boundary.
  - Never loaded at any other time. An input change mid-frame is invisible until the next frame.
- Scan decision:
  - cnt < BLANK_CYCLES: an = 4'b1111, seg = 7'b1111111.
  - Otherwise: an = ~(4'b0001 << idx), seg = glyph(sh[idx]).
  - A blank code still asserts its anode, but with all segments off.
- There is no other state machine; the scan sequence is idx 0 → 1 → 2 → 3 → 0.

## Timing
- Reset values:
  - Internal: cnt = 0, idx = 0, sh0..sh3 = OFF_CODE.
  - Outputs: an = 4'b1111, seg = 7'b1111111, dp = 1, frame_tick = 0.
- an and seg are registered. Each reflects the cnt, idx and shadow values of the previous cycle (1-cycle latency).
  - Example: the anode first goes low in the cycle after cnt = BLANK_CYCLES.
- Frame length is 4 × REFRESH_DIV cycles.
- The first snapshot occurs at cycle 4 × REFRESH_DIV − 1 after reset release. Before that, all digits display blank.
- frame_tick is high for exactly the one cycle following the snapshot cycle.
- Snapshot and idx wrap happen in the same cycle. The first slot of the new frame therefore shows the new sh0.
- Reset asserted mid-slot: all outputs go to reset values immediately (asynchronous). The scan restarts from idx 0 with blank shadows.

## Structure
- Shared package calc_disp_pkg:
  - OFF_CODE
  - the 16 glyph constants
  - the active-low segment bit-order convention
- Sub-module hex_to_seg: combinational 5-bit code → 7-bit active-low glyph, including the bit-4 blank rule. This module is reused by any future status display.
- seven_seg_scanner holds cnt, idx, the shadows and the output registers.

## Test plan
Use REFRESH_DIV = 8, BLANK_CYCLES = 2 throughout.
- Reset, with disp0..3 = 8'h01, 8'h02, 8'h03, 8'h04:
  - First frame (cycles 0–31): an never leaves 4'b1111 during blank, and seg = 7'b1111111 throughout.
  - frame_tick = 1 at cycle 32.
- Second frame:
  - Each slot shows an = 4'b1111 for 2 cycles, then an[idx] low for 6 cycles.
  - Slot 0 shows seg = 1111001, and so on for 2, 3, 4.
  - Order is an = 1110, 1101, 1011, 0111.
- Change disp2 from 8'h03 to 8'h0F mid-frame:
  - The current frame still shows 0110000 on an[2].
  - The next frame shows 0001110.
- disp1 = 8'h10 (OFF_CODE) and disp3 = 8'hE5:
  - Slot 1: anode asserted with seg = 7'b1111111.
  - Slot 3: bits [7:5] are ignored, and it shows glyph 5 = 0010010.
- Assert reset_n low at cnt = 5, idx = 2:
  - an = 4'b1111, seg = 7'b1111111 and frame_tick = 0 within the same cycle.
  - After release, digits stay blank for a full frame.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared display constants for the calculator's seven-segment drivers.
// Segment vectors are {g,f,e,d,c,b,a}, active-low: a 0 bit lights that segment.
package calc_disp_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [4:0] code_t;
    typedef logic [1:0] digit_idx_t;

    localparam code_t OFF_CODE  = 5'b10000;
    localparam seg_t  SEG_BLANK = 7'b1111111;

    // Entries are listed from glyph F down to glyph 0.
    localparam logic [15:0][6:0] GLYPH_TBL = '{
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Digit codes in, multiplexed anode/segment drive out.
// The display side has no flow control: codes are sampled once per frame.
interface seven_seg_scanner_if;
    logic [7:0] disp0;
    logic [7:0] disp1;
    logic [7:0] disp2;
    logic [7:0] disp3;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output disp0, disp1, disp2, disp3,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  disp0, disp1, disp2, disp3,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/hex_to_seg.sv
// Combinational 5-bit digit code to active-low glyph; codes with bit 4 set are blank.
// Zero latency, no backpressure.
module hex_to_seg
    import calc_disp_pkg::*;
(
    input  code_t code,
    output seg_t  seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!code[4]) begin
            seg = GLYPH_TBL[code[3:0]];
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Scans four snapshotted digit codes onto shared segment lines, blanking the start of each slot.
// an/seg are registered one cycle behind cnt/idx; inputs are only sampled at the frame boundary.
module seven_seg_scanner
    import calc_disp_pkg::*;
#(
    parameter int    REFRESH_DIV  = 50000,
    parameter int    BLANK_CYCLES = 1000,
    parameter code_t OFF_CODE     = calc_disp_pkg::OFF_CODE
) (
    input  logic                clk,
    input  logic                reset_n,
    seven_seg_scanner_if.slave  bus
);

    localparam int             CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    digit_idx_t    idx;
    code_t         sh [4];
    logic [3:0]    an_q;
    seg_t          seg_q;
    logic          tick_q;

    logic          slot_end;
    logic          frame_end;
    logic          in_blank;
    seg_t          glyph;
    logic [3:0]    an_nxt;
    seg_t          seg_nxt;
    logic          unused_hi;

    // Upper code bits carry no display meaning.
    assign unused_hi = ^{bus.disp0[7:5], bus.disp1[7:5], bus.disp2[7:5], bus.disp3[7:5]};

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);
    assign in_blank  = (cnt < CNT_BLANK);

    hex_to_seg u_hex_to_seg (
        .code (sh[idx]),
        .seg  (glyph)
    );

    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = SEG_BLANK;
        if (!in_blank) begin
            an_nxt  = ~(4'b0001 << idx);
            seg_nxt = glyph;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            idx    <= '0;
            for (int i = 0; i < 4; i++) begin
                sh[i] <= OFF_CODE;
            end
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
            tick_q <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
            // Snapshot coincides with the idx wrap so slot 0 of the new frame sees new sh[0].
            if (frame_end) begin
                sh[0] <= bus.disp0[4:0];
                sh[1] <= bus.disp1[4:0];
                sh[2] <= bus.disp2[4:0];
                sh[3] <= bus.disp3[4:0];
            end
            an_q   <= an_nxt;
            seg_q  <= seg_nxt;
            tick_q <= frame_end;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scanner;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    seven_seg_scanner_if bus ();

    seven_seg_scanner #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .OFF_CODE     (5'b10000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Outputs in cycle c reflect cnt/idx of cycle c-1; cnt = c%8, idx = (c/8)%4.
    task automatic run_frame(input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3, input int n);
        logic [6:0] g [4];
        int         p;
        int         pc;
        int         pi;
        logic [3:0] ea;
        logic [6:0] es;
        g = '{g0, g1, g2, g3};
        for (int k = 0; k < n; k++) begin
            step();
            p  = cyc - 1;
            pc = p % 8;
            pi = (p / 8) % 4;
            if (pc < 2) begin
                ea = 4'b1111;
                es = 7'b1111111;
            end else begin
                ea = ~(4'b0001 << pi);
                es = g[pi];
            end
            chk($sformatf("an@%0d", cyc), 8'(bus.an), 8'(ea));
            chk($sformatf("seg@%0d", cyc), 8'(bus.seg), 8'(es));
            chk($sformatf("tick@%0d", cyc), 8'(bus.frame_tick), 8'((cyc % 32) == 0));
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.disp0 = 8'h01;
        bus.disp1 = 8'h02;
        bus.disp2 = 8'h03;
        bus.disp3 = 8'h04;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_an",   8'(bus.an),         8'h0F);
        chk("rst_seg",  8'(bus.seg),        8'h7F);
        chk("rst_dp",   8'(bus.dp),         8'h01);
        chk("rst_tick", 8'(bus.frame_tick), 8'h00);

        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
        #1;
        chk("c0_an",  8'(bus.an),  8'h0F);
        chk("c0_seg", 8'(bus.seg), 8'h7F);

        // Frame 0: shadows still blank; tick at cycle 32.
        run_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 32);

        // Frame 1 shows 1,2,3,4; inputs change mid-frame and must not leak in.
        run_frame(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 12);
        bus.disp2 = 8'h0F;
        bus.disp1 = 8'h10;
        bus.disp3 = 8'hE5;
        run_frame(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 20);
        chk("dp_run", 8'(bus.dp), 8'h01);

        // Frame 2: blank code on digit 1 (anode still on), F on digit 2, E5 -> 5 on digit 3.
        run_frame(7'b1111001, 7'b1111111, 7'b0001110, 7'b0010010, 32);

        // Into frame 3 up to cnt=5, idx=2 (cycle 117).
        run_frame(7'b1111001, 7'b1111111, 7'b0001110, 7'b0010010, 21);
        chk("pre_rst_an",  8'(bus.an),  8'h0B);
        chk("pre_rst_seg", 8'(bus.seg), 8'h0E);

        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_an",   8'(bus.an),         8'h0F);
        chk("midrst_seg",  8'(bus.seg),        8'h7F);
        chk("midrst_tick", 8'(bus.frame_tick), 8'h00);
        chk("midrst_dp",   8'(bus.dp),         8'h01);

        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
        #1;
        chk("rel_an",  8'(bus.an),  8'h0F);
        chk("rel_seg", 8'(bus.seg), 8'h7F);

        // After reset the shadows are blank again despite non-blank inputs.
        run_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 32);

        // First post-reset frame picks up the live inputs.
        run_frame(7'b1111001, 7'b1111111, 7'b0001110, 7'b0010010, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
